// File: rtl/seq_add_sub.sv
// Multi-cycle adder/subtractor: one SLICE-bit ripple stage reused across WIDTH/SLICE cycles.
// start/done handshake; registered sum, carry-out and signed-overflow flags.
module seq_add_sub #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned K  = WIDTH / SLICE;
   localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   opa_q;
   logic [WIDTH-1:0]   opb_q;
   logic [WIDTH-1:0]   res_q;
   logic [WIDTH-1:0]   res_d;
   logic               carry_q;
   logic [CW-1:0]      cnt_q;
   logic               amsb_q;
   logic               bmsb_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   sum_q;
   logic               cout_q;
   logic               ovf_q;
   logic [SLICE:0]     slice_sum;
   logic [WIDTH-1:0]   b_eff;

   always_comb begin
      slice_sum = {1'b0, opa_q[SLICE-1:0]} + {1'b0, opb_q[SLICE-1:0]}
                + {{SLICE{1'b0}}, carry_q};
      b_eff     = b ^ {WIDTH{sub}};
   end

   // New slice enters at the MSB end so the result is LSB-aligned after K slices.
   generate
      if (K == 1) begin : g_single
         assign res_d = slice_sum[SLICE-1:0];
      end else begin : g_multi
         assign res_d = {slice_sum[SLICE-1:0], res_q[WIDTH-1:SLICE]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         amsb_q  <= 1'b0;
         bmsb_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  opa_q   <= a;
                  opb_q   <= b_eff;
                  carry_q <= sub;
                  cnt_q   <= '0;
                  amsb_q  <= a[WIDTH-1];
                  bmsb_q  <= b_eff[WIDTH-1];
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               res_q   <= res_d;
               opa_q   <= opa_q >> SLICE;
               opb_q   <= opb_q >> SLICE;
               carry_q <= slice_sum[SLICE];
               cnt_q   <= cnt_q + CW'(1);
               if (cnt_q == CW'(K - 1)) begin
                  sum_q   <= res_d;
                  cout_q  <= slice_sum[SLICE];
                  ovf_q   <= (amsb_q == bmsb_q) && (slice_sum[SLICE-1] != amsb_q);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// Directed bench for seq_add_sub: default 16/4 instance plus a 4/4 single-slice instance.
module tb_seq_add_sub;

   logic        clk;
   logic        rst_n;
   logic        start, sub;
   logic [15:0] a, b;
   logic        busy, done, cout, ovf;
   logic [15:0] sum;

   logic        start4, sub4;
   logic [3:0]  a4, b4;
   logic        busy4, done4, cout4, ovf4;
   logic [3:0]  sum4;

   int n_tests = 0;
   int n_fail  = 0;

   seq_add_sub #(.WIDTH(16), .SLICE(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   seq_add_sub #(.WIDTH(4), .SLICE(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called #1 after an edge inside RUN; waits (bounded) for done and checks the result.
   task automatic wait_result(input string tag, input int exp_edges, input int exp_busy,
                              input logic [15:0] es, input logic ec, input logic ev);
      int edges  = 0;
      int busy_c = 0;
      while (!done && edges < 20) begin
         if (busy) busy_c++;
         @(posedge clk); #1;
         edges++;
      end
      check({tag, "_edges"}, edges, exp_edges);
      check({tag, "_busy"},  busy_c, exp_busy);
      check({tag, "_done"},  done, 1'b1);
      check({tag, "_sum"},   sum, es);
      check({tag, "_cout"},  cout, ec);
      check({tag, "_ovf"},   ovf, ev);
   endtask

   task automatic do_op(input string tag, input logic [15:0] ai, input logic [15:0] bi,
                        input logic si, input logic [15:0] es, input logic ec, input logic ev);
      a = ai; b = bi; sub = si; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_result(tag, 4, 4, es, ec, ev);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, done, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
      #12;
      check("rst_sum",  sum, 16'h0000);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_flags", {cout, ovf}, 2'b00);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single-slice variant: 9 + 8 -> 1, carry and overflow.
      a4 = 4'd9; b4 = 4'd8; sub4 = 1'b0; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      check("w4_busy", busy4, 1'b1);
      check("w4_early", done4, 1'b0);
      @(posedge clk); #1;
      check("w4_done", done4, 1'b1);
      check("w4_sum",  sum4, 4'd1);
      check("w4_flags", {cout4, ovf4}, 2'b11);
      check("w4_idle", busy4, 1'b0);

      do_op("add",   16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
      do_op("sub1",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      do_op("ovadd", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      do_op("wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      do_op("sub2",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // Start re-pulsed mid-RUN with other operands must be ignored.
      a = 16'h1234; b = 16'h0FFF; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_result("ignore", 2, 2, 16'h2233, 1'b0, 1'b0);

      // Start held in DONE launches the next operation with no idle gap.
      a = 16'h0010; b = 16'h0001; sub = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_busy", busy, 1'b1);
      check("b2b_hold", sum, 16'h2233);
      wait_result("b2b", 4, 4, 16'h000F, 1'b1, 1'b0);
      @(posedge clk); #1;

      // Prime non-zero outputs, then reset between edges during slice 2.
      do_op("pre", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      check("arst_sum",   sum, 16'h0000);
      check("arst_busy",  busy, 1'b0);
      check("arst_flags", {done, cout, ovf}, 3'b000);
      @(posedge clk); #1;
      check("arst_hold", busy, 1'b0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check("arst_idle", {busy, done}, 2'b00);
      do_op("post", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
